uart_frame_parser: RTL

//  Consumes the byte stream from the UART receiver (rx_data / rx_done) and parses command frames:
//  0x55 0xAA CMD LEN_H LEN_L PAYLOAD[LEN] CHK.

---
 rtl/uart_frame_pkg.sv | 23 ++
 rtl/uart_gap_timer.sv | 38 +++
 rtl/uart_frame_parser.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/uart_frame_pkg.sv
// Shared encodings for the UART command-frame parser: FSM states, sync/ACK bytes and error codes.
package uart_frame_pkg;

    typedef enum logic [2:0] {
        ST_HUNT,
        ST_SYNC1,
        ST_CMD,
        ST_LENH,
        ST_LENL,
        ST_DATA,
        ST_CHK
    } state_t;

    localparam logic [7:0] SYNC0 = 8'h55;
    localparam logic [7:0] SYNC1 = 8'hAA;
    localparam logic [7:0] ACK   = 8'h06;
    localparam logic [7:0] NAK   = 8'h15;

    localparam logic [1:0] ERR_CHK = 2'd1;
    localparam logic [1:0] ERR_LEN = 2'd2;
    localparam logic [1:0] ERR_TMO = 2'd3;

endpackage

// File: rtl/uart_gap_timer.sv
// Inter-byte gap counter. tc fires on the cycle the count steps onto TIMEOUT_CLKS-1,
// so the parser's registered error lands on the same edge the count reaches its limit.
module uart_gap_timer #(
    parameter int TIMEOUT_CLKS = 17360
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int CW = (TIMEOUT_CLKS > 2) ? $clog2(TIMEOUT_CLKS) : 1;
    localparam logic [CW-1:0] TC_VAL = CW'(TIMEOUT_CLKS - 2);

    logic [CW-1:0] cnt_reg;
    logic [CW-1:0] cnt_next;

    always_comb begin
        cnt_next = cnt_reg;
        if (clr) begin
            cnt_next = '0;
        end else if (en) begin
            cnt_next = cnt_reg + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

    assign tc = en && !clr && (cnt_reg == TC_VAL);

endmodule

// File: rtl/uart_frame_parser.sv
// Parses 55 AA CMD LEN_H LEN_L PAYLOAD CHK frames from the UART byte stream, streams the
// payload, and reports each frame's outcome with an optional ACK/NAK byte toward UART TX.
module uart_frame_parser
    import uart_frame_pkg::*;
#(
    parameter int          SYS_CLK_FRP  = 50_000_000,
    parameter int          BAUDRATE     = 115200,
    parameter int          TIMEOUT_CLKS = (SYS_CLK_FRP / BAUDRATE) * 40,
    parameter logic [15:0] MAX_LEN      = 16'd4096,
    parameter bit          ACK_EN       = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_done,
    output logic [7:0]  cmd,
    output logic [7:0]  pay_data,
    output logic        pay_valid,
    output logic [15:0] pay_idx,
    output logic        busy,
    output logic        frame_ok,
    output logic        frame_err,
    output logic [1:0]  err_code,
    output logic [7:0]  tx_data,
    output logic        tx_en
);

    state_t      state_reg, state_next;
    logic [7:0]  sum_reg, sum_next;
    logic [15:0] len_reg, len_next;
    logic [15:0] idx_reg, idx_next;
    logic [7:0]  cmd_reg, cmd_next;
    logic [7:0]  pay_data_reg, pay_data_next;
    logic        pay_valid_reg, pay_valid_next;
    logic [15:0] pay_idx_reg, pay_idx_next;
    logic        frame_ok_reg, frame_ok_next;
    logic        frame_err_reg, frame_err_next;
    logic [1:0]  err_code_reg, err_code_next;
    logic [7:0]  tx_data_reg, tx_data_next;
    logic        tx_en_reg, tx_en_next;

    logic        tmo_tc;
    logic        ok_hit;
    logic        err_hit;
    logic [1:0]  err_sel;
    logic [15:0] len_new;

    uart_gap_timer #(
        .TIMEOUT_CLKS(TIMEOUT_CLKS)
    ) u_gap_timer (
        .clk (clk),
        .rst (rst),
        .clr (rx_done || (state_reg == ST_HUNT)),
        .en  (state_reg != ST_HUNT),
        .tc  (tmo_tc)
    );

    always_comb begin
        state_next     = state_reg;
        sum_next       = sum_reg;
        len_next       = len_reg;
        idx_next       = idx_reg;
        cmd_next       = cmd_reg;
        pay_data_next  = pay_data_reg;
        pay_valid_next = 1'b0;
        pay_idx_next   = pay_idx_reg;
        frame_ok_next  = 1'b0;
        frame_err_next = 1'b0;
        err_code_next  = err_code_reg;
        tx_data_next   = tx_data_reg;
        tx_en_next     = 1'b0;
        ok_hit         = 1'b0;
        err_hit        = 1'b0;
        err_sel        = ERR_CHK;
        len_new        = {len_reg[15:8], rx_data};

        if (rx_done) begin
            unique case (state_reg)
                ST_HUNT: begin
                    if (rx_data == SYNC0) state_next = ST_SYNC1;
                end
                ST_SYNC1: begin
                    if (rx_data == SYNC1)      state_next = ST_CMD;
                    else if (rx_data != SYNC0) state_next = ST_HUNT;
                end
                ST_CMD: begin
                    cmd_next   = rx_data;
                    sum_next   = rx_data;
                    state_next = ST_LENH;
                end
                ST_LENH: begin
                    len_next   = {rx_data, len_reg[7:0]};
                    sum_next   = sum_reg + rx_data;
                    state_next = ST_LENL;
                end
                ST_LENL: begin
                    len_next = len_new;
                    sum_next = sum_reg + rx_data;
                    if (len_new > MAX_LEN) begin
                        err_hit = 1'b1;
                        err_sel = ERR_LEN;
                    end else if (len_new == 16'd0) begin
                        state_next = ST_CHK;
                    end else begin
                        idx_next   = 16'd0;
                        state_next = ST_DATA;
                    end
                end
                ST_DATA: begin
                    pay_valid_next = 1'b1;
                    pay_data_next  = rx_data;
                    pay_idx_next   = idx_reg;
                    sum_next       = sum_reg + rx_data;
                    if (idx_reg == len_reg - 16'd1) state_next = ST_CHK;
                    else                            idx_next   = idx_reg + 16'd1;
                end
                ST_CHK: begin
                    if (rx_data == sum_reg) begin
                        ok_hit = 1'b1;
                    end else begin
                        err_hit = 1'b1;
                        err_sel = ERR_CHK;
                    end
                    state_next = ST_HUNT;
                end
                default: state_next = ST_HUNT;
            endcase
        end else if (tmo_tc && (state_reg != ST_SYNC1)) begin
            // While hunting for 0xAA the parser is not yet committed to a frame.
            err_hit = 1'b1;
            err_sel = ERR_TMO;
        end

        if (ok_hit) begin
            frame_ok_next = 1'b1;
            if (ACK_EN) begin
                tx_en_next   = 1'b1;
                tx_data_next = ACK;
            end
        end
        if (err_hit) begin
            frame_err_next = 1'b1;
            err_code_next  = err_sel;
            state_next     = ST_HUNT;
            if (ACK_EN) begin
                tx_en_next   = 1'b1;
                tx_data_next = NAK;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= ST_HUNT;
            sum_reg       <= '0;
            len_reg       <= '0;
            idx_reg       <= '0;
            cmd_reg       <= '0;
            pay_data_reg  <= '0;
            pay_valid_reg <= 1'b0;
            pay_idx_reg   <= '0;
            frame_ok_reg  <= 1'b0;
            frame_err_reg <= 1'b0;
            err_code_reg  <= '0;
            tx_data_reg   <= '0;
            tx_en_reg     <= 1'b0;
        end else begin
            state_reg     <= state_next;
            sum_reg       <= sum_next;
            len_reg       <= len_next;
            idx_reg       <= idx_next;
            cmd_reg       <= cmd_next;
            pay_data_reg  <= pay_data_next;
            pay_valid_reg <= pay_valid_next;
            pay_idx_reg   <= pay_idx_next;
            frame_ok_reg  <= frame_ok_next;
            frame_err_reg <= frame_err_next;
            err_code_reg  <= err_code_next;
            tx_data_reg   <= tx_data_next;
            tx_en_reg     <= tx_en_next;
        end
    end

    assign cmd       = cmd_reg;
    assign pay_data  = pay_data_reg;
    assign pay_valid = pay_valid_reg;
    assign pay_idx   = pay_idx_reg;
    assign busy      = (state_reg != ST_HUNT);
    assign frame_ok  = frame_ok_reg;
    assign frame_err = frame_err_reg;
    assign err_code  = err_code_reg;
    assign tx_data   = tx_data_reg;
    assign tx_en     = tx_en_reg;

endmodule
